// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2 DIT FFT address generation unit.
// FFT size, counter/field widths and the sequencer state encoding live here.
package fft_pkg;

    localparam int LOG2N   = 5;
    localparam int N       = 1 << LOG2N;
    localparam int STAGE_W = $clog2(LOG2N);
    localparam int TW_W    = LOG2N - 1;
    localparam int BFLY_W  = LOG2N - 1;

    typedef logic [STAGE_W-1:0] stage_t;
    typedef logic [TW_W-1:0]    tw_t;
    typedef logic [BFLY_W-1:0]  bfly_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fft_agu_if.sv
// RAM/BFU-facing bundle of the FFT AGU: start handshake, RAM addresses and
// strobes, BFU operand-valid flag, twiddle index and stage number.
interface fft_agu_if #(
    parameter int ADDR_W = 8
);
    logic                start;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;
    logic                wr_a;
    logic                wr_b;
    logic                bfu_load;
    fft_pkg::tw_t        tw_idx;
    fft_pkg::stage_t     stage;

    modport master (
        input  start,
        output busy, done, addr_a, addr_b, wr_a, wr_b, bfu_load, tw_idx, stage
    );

    modport slave (
        output start,
        input  busy, done, addr_a, addr_b, wr_a, wr_b, bfu_load, tw_idx, stage
    );
endinterface

// File: rtl/fft_addr_map.sv
// Combinational butterfly address map: (stage s, butterfly j) -> upper leg a,
// lower leg b = a + 2^s, and twiddle index k for W_N^k.
module fft_addr_map
    import fft_pkg::*;
(
    input  stage_t           s_i,
    input  bfly_t            j_i,
    output logic [LOG2N-1:0] a_o,
    output logic [LOG2N-1:0] b_o,
    output tw_t              tw_o
);
    logic [LOG2N-1:0] j_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] low;

    // Insert a zero at bit s of j to get the upper leg; the lower leg sets that bit.
    always_comb begin
        j_ext = LOG2N'(j_i);
        span  = LOG2N'(1) << s_i;
        low   = j_ext & (span - LOG2N'(1));
        a_o   = ((j_ext >> s_i) << (s_i + stage_t'(1))) | low;
        b_o   = a_o | span;
        tw_o  = tw_t'(low << (stage_t'(LOG2N - 1) - s_i));
    end
endmodule

// File: rtl/fft_agu.sv
// In-place radix-2 DIT FFT address generation unit: walks every butterfly of
// every stage as READ / WAIT x BFU_LAT / WRITE and drives registered RAM controls.
module fft_agu
    import fft_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int BFU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    fft_agu_if.master  bus
);
    localparam int     WAIT_W = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;
    localparam bfly_t  J_MAX  = bfly_t'(N / 2 - 1);
    localparam stage_t S_MAX  = stage_t'(LOG2N - 1);

    state_e            state_q, state_d;
    stage_t            s_q, s_d;
    bfly_t             j_q, j_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    tw_t               tw_q;
    stage_t            stage_q;
    logic              wr_q, bfu_load_q, busy_q, done_q;

    logic [LOG2N-1:0]  map_a, map_b;
    tw_t               map_tw;
    logic              active_d;

    // Outputs are registered, so they are decoded from the next-state counters.
    fft_addr_map u_addr_map (
        .s_i  (s_d),
        .j_i  (j_d),
        .a_o  (map_a),
        .b_o  (map_b),
        .tw_o (map_tw)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_READ;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
                wait_d  = '0;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_W'(BFU_LAT - 1)) state_d = ST_WRITE;
                else                                wait_d  = wait_q + WAIT_W'(1);
            end
            ST_WRITE: begin
                if (j_q != J_MAX) begin
                    j_d     = j_q + bfly_t'(1);
                    state_d = ST_READ;
                end else if (s_q != S_MAX) begin
                    j_d     = '0;
                    s_d     = s_q + stage_t'(1);
                    state_d = ST_READ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
                j_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign active_d = (state_d == ST_READ) || (state_d == ST_WAIT) || (state_d == ST_WRITE);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and registers take <= so every flop updates from pre-edge values.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            wait_q     <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            tw_q       <= '0;
            stage_q    <= '0;
            wr_q       <= 1'b0;
            bfu_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            wait_q     <= wait_d;
            addr_a_q   <= active_d ? ADDR_W'(map_a) : '0;
            addr_b_q   <= active_d ? ADDR_W'(map_b) : '0;
            tw_q       <= active_d ? map_tw : '0;
            stage_q    <= active_d ? s_d : '0;
            wr_q       <= (state_d == ST_WRITE);
            // The RAM read issued in READ is valid in the first WAIT cycle.
            bfu_load_q <= (state_q == ST_READ);
            busy_q     <= active_d;
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.addr_a   = addr_a_q;
    assign bus.addr_b   = addr_b_q;
    assign bus.wr_a     = wr_q;
    assign bus.wr_b     = wr_q;
    assign bus.bfu_load = bfu_load_q;
    assign bus.tw_idx   = tw_q;
    assign bus.stage    = stage_q;
endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu: a timeline model derived from butterfly order
// and cycle position, plus RAM/BFU model, run statistics and literal pins.
module tb_fft_agu;
    import fft_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int BFU_LAT = 1;
    localparam int L       = BFU_LAT + 2;
    localparam int NB      = N / 2;
    localparam int TOTAL   = LOG2N * NB * L;
    localparam real PI     = 3.14159265358979323846;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_agu_if #(.ADDR_W(ADDR_W)) bus ();

    fft_agu #(.ADDR_W(ADDR_W), .BFU_LAT(BFU_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    int  m_pos    = -1;
    bit  checking = 1'b0;

    int  wcount [N];
    int  n_wr, n_busy, n_done, first_busy, last_wr, done_cyc;
    int  obs_a [LOG2N*NB];
    int  obs_b [LOG2N*NB];
    int  obs_tw[LOG2N*NB];

    real ram_re [N];
    real ram_im [N];
    real op_ar, op_ai, op_br, op_bi, wc, ws, tr, ti;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Butterfly j of stage s: group of 2*span points, offset k inside the group.
    function automatic void model_map(input int s, input int j, output int a, output int b, output int tw);
        int span, grp, k;
        span = 1 << s;
        grp  = j / span;
        k    = j % span;
        a    = grp * 2 * span + k;
        b    = a + span;
        tw   = k * (N / (2 * span));
    endfunction

    // Expected output word for cycle position pos of a run (1 = first READ).
    function automatic logic [27:0] expected(input int pos);
        int a, b, tw, bi, ph, s, j;
        logic [27:0] e;
        e = '0;
        if (pos >= 1 && pos <= TOTAL) begin
            bi = (pos - 1) / L;
            ph = (pos - 1) % L;
            s  = bi / NB;
            j  = bi % NB;
            model_map(s, j, a, b, tw);
            e = {1'b1, 1'b0, (ph == L - 1), (ph == L - 1), (ph == 1),
                 3'(s), 4'(tw), 8'(a), 8'(b)};
        end else if (pos == TOTAL + 1) begin
            e[26] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [27:0] actual();
        return {bus.busy, bus.done, bus.wr_a, bus.wr_b, bus.bfu_load,
                bus.stage, bus.tw_idx, bus.addr_a, bus.addr_b};
    endfunction

    // Timeline model: position within a run, advanced from the rules on start/reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n)                 m_pos <= -1;
        else if (m_pos == -1)       m_pos <= bus.start ? 1 : -1;
        else if (m_pos <= TOTAL)    m_pos <= m_pos + 1;
        else                        m_pos <= -1;
    end

    always @(negedge clk) begin
        if (checking) begin
            check($sformatf("cycle%0d_pos%0d", cyc, m_pos), 64'(actual()), 64'(expected(m_pos)));
            if (bus.busy) begin
                n_busy++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (bus.wr_a) begin
                wcount[bus.addr_a[LOG2N-1:0]]++;
                n_wr++;
                last_wr = cyc;
            end
            if (bus.wr_b) wcount[bus.addr_b[LOG2N-1:0]]++;
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (m_pos >= 1 && m_pos <= TOTAL && (m_pos - 1) % L == 0) begin
                obs_a [(m_pos - 1) / L] = int'(bus.addr_a);
                obs_b [(m_pos - 1) / L] = int'(bus.addr_b);
                obs_tw[(m_pos - 1) / L] = int'(bus.tw_idx);
            end
            if (bus.bfu_load) begin
                op_ar = ram_re[bus.addr_a[LOG2N-1:0]];
                op_ai = ram_im[bus.addr_a[LOG2N-1:0]];
                op_br = ram_re[bus.addr_b[LOG2N-1:0]];
                op_bi = ram_im[bus.addr_b[LOG2N-1:0]];
            end
            if (bus.wr_a && bus.wr_b) begin
                wc = $cos(2.0 * PI * real'(bus.tw_idx) / real'(N));
                ws = $sin(2.0 * PI * real'(bus.tw_idx) / real'(N));
                tr = op_br * wc + op_bi * ws;
                ti = op_bi * wc - op_br * ws;
                ram_re[bus.addr_a[LOG2N-1:0]] = op_ar + tr;
                ram_im[bus.addr_a[LOG2N-1:0]] = op_ai + ti;
                ram_re[bus.addr_b[LOG2N-1:0]] = op_ar - tr;
                ram_im[bus.addr_b[LOG2N-1:0]] = op_ai - ti;
            end
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < N; i++) wcount[i] = 0;
        n_wr = 0; n_busy = 0; n_done = 0;
        first_busy = -1; last_wr = -1; done_cyc = -1;
    endtask

    // mode 0: quiet, 1: stray start at run cycle 50, 2: random start noise.
    task automatic do_run(input string tag, input int mode);
        int start_cyc, k;
        clear_stats();
        bus.start = 1'b1;
        start_cyc = cyc;
        tick();
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < TOTAL + 20) begin
            bus.start = (mode == 1 && k == 50) || (mode == 2 && $urandom_range(0, 3) == 0);
            tick();
            bus.start = 1'b0;
            k++;
        end
        check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        if (mode != 0) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_idle_after_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_write_cycles"}, 64'(n_wr), 64'd80);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_writes_addr%0d", tag, i), 64'(wcount[i]), 64'd5);
        check({tag, "_busy_cycles"}, 64'(n_busy), 64'(TOTAL));
        check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
        check({tag, "_done_after_last_wr"}, 64'(done_cyc - last_wr), 64'd1);
        check({tag, "_read_to_write_span"}, 64'(last_wr - first_busy + 1), 64'd240);
        check({tag, "_done_latency"}, 64'(done_cyc - start_cyc), 64'd241);
    endtask

    initial begin
        int a, b, tw, target, k;
        bool_dummy: begin end
        bus.start = 1'b0;
        rst_n     = 1'b0;
        tick();
        checking = 1'b1;
        tick();
        check("reset_outputs", 64'(actual()), 64'd0);

        model_map(0, 0, a, b, tw);
        check("model_s0_j0", 64'({a, b, tw}), 64'({32'd0, 32'd1, 32'd0}));
        model_map(0, 3, a, b, tw);
        check("model_s0_j3", 64'({a, b, tw}), 64'({32'd6, 32'd7, 32'd0}));
        model_map(2, 5, a, b, tw);
        check("model_s2_j5", 64'({a, b, tw}), 64'({32'd9, 32'd13, 32'd4}));
        model_map(4, 15, a, b, tw);
        check("model_s4_j15", 64'({a, b, tw}), 64'({32'd15, 32'd31, 32'd15}));

        rst_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) begin
            ram_re[i] = 0.0;
            ram_im[i] = 0.0;
        end
        ram_re[0] = 1.0;
        do_run("run1", 0);
        for (int i = 0; i < N; i++)
            check($sformatf("impulse_bin%0d", i),
                  64'((ram_re[i] > 0.999999) && (ram_re[i] < 1.000001) &&
                      (ram_im[i] > -0.000001) && (ram_im[i] < 0.000001)), 64'd1);
        check("dut_s0_j0", 64'({8'(obs_a[0]),  8'(obs_b[0]),  8'(obs_tw[0])}),  64'({8'd0,  8'd1,  8'd0}));
        check("dut_s0_j3", 64'({8'(obs_a[3]),  8'(obs_b[3]),  8'(obs_tw[3])}),  64'({8'd6,  8'd7,  8'd0}));
        check("dut_s2_j5", 64'({8'(obs_a[37]), 8'(obs_b[37]), 8'(obs_tw[37])}), 64'({8'd9,  8'd13, 8'd4}));
        check("dut_s4_j15",64'({8'(obs_a[79]), 8'(obs_b[79]), 8'(obs_tw[79])}), 64'({8'd15, 8'd31, 8'd15}));

        repeat (3) tick();
        do_run("run2_stray_start", 1);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        target = (2 * NB + int'($urandom_range(0, NB - 1))) * L + 2;
        k = 0;
        while (m_pos != target && k < TOTAL + 20) begin
            tick();
            k++;
        end
        check("reach_stage2_wait", 64'(m_pos), 64'(target));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_run_reset_outputs", 64'(actual()), 64'd0);
        tick();
        do_run("run3_after_reset", 0);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 5)) tick();
            do_run($sformatf("rand_run%0d", r), 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
